// File: rtl/vga_scanout_if.sv
// Read-only VRAM port between the scanout engine (master) and the video RAM (slave).
// Read data follows the address by one registered stage on the RAM side.
interface vga_scanout_if;
  logic [15:0] vaddr;
  logic [15:0] vout;

  modport master (output vaddr, input vout);
  modport slave  (input vaddr, output vout);
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, scaled/centred framebuffer walk, VRAM read pipeline and RGB/sync drive.
// Every output is aligned to the raster position the counters held three cycles earlier.
module vga_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_W    = 128,
  parameter int          IMG_H    = 124,
  parameter int          SCALE    = 3,
  parameter int          H_OFF    = 128,
  parameter int          V_OFF    = 54,
  parameter logic [15:0] BORDER   = 16'h0000
) (
  input  logic                 vclk,
  input  logic                 rst,
  vga_scanout_if.master        vram,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vblank,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HX0    = HW'(H_OFF);
  localparam logic [HW-1:0] HX1    = HW'(H_OFF + IMG_W * SCALE);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VY0    = VW'(V_OFF);
  localparam logic [VW-1:0] VY1    = VW'(V_OFF + IMG_H * SCALE);
  localparam logic [SW-1:0] REP_MAX = SW'(SCALE - 1);

  typedef struct packed {
    logic active;
    logic img;
    logic hs;
    logic vs;
    logic fs;
    logic vb;
  } tag_t;

  localparam tag_t BLANK = '{active: 1'b0, img: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, vb: 1'b0};

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] x_rep, y_rep;
  logic          h_win, v_win, in_img;
  tag_t          t0;
  tag_t [2:1]    tag_pipe;
  logic [14:0]   pix;

  // Raster counters
  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_MAX) begin
      hc <= '0;
      vc <= (vc == V_MAX) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign h_win  = (hc >= HX0) && (hc < HX1);
  assign v_win  = (vc >= VY0) && (vc < VY1);
  assign in_img = h_win && v_win;

  // Replicate sub-counters stand in for (hc-H_OFF)/SCALE and (vc-V_OFF)/SCALE.
  // Outside the window they sit at zero, so the first window column/line starts clean.
  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      x_rep <= '0;
    end else if (h_win) begin
      if (x_rep == REP_MAX) begin
        x_rep <= '0;
        col   <= col + 1'b1;
      end else begin
        x_rep <= x_rep + 1'b1;
      end
    end else begin
      col   <= '0;
      x_rep <= '0;
    end
  end

  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      row   <= '0;
      y_rep <= '0;
    end else if (hc == H_MAX) begin
      if (!v_win) begin
        row   <= '0;
        y_rep <= '0;
      end else if (y_rep == REP_MAX) begin
        y_rep <= '0;
        row   <= row + 1'b1;
      end else begin
        y_rep <= y_rep + 1'b1;
      end
    end
  end

  // IMG_W is a power of two, so row*IMG_W+col is a plain concatenation
  always_ff @(posedge vclk or negedge rst) begin
    if (!rst)
      vram.vaddr <= '0;
    else if (in_img)
      vram.vaddr <= 16'({row, col});
  end

  always_comb begin
    t0        = BLANK;
    t0.active = (hc < H_ACT) && (vc < V_ACT);
    t0.img    = in_img;
    t0.hs     = !((hc >= HS_BEG) && (hc < HS_END));
    t0.vs     = !((vc >= VS_BEG) && (vc < VS_END));
    t0.fs     = (hc == '0) && (vc == '0);
    t0.vb     = (vc >= V_ACT);
  end

  // Status travels alongside the address/data so it lines up with the RAM latency
  always_ff @(posedge vclk or negedge rst) begin
    if (!rst)
      tag_pipe <= {2{BLANK}};
    else begin
      tag_pipe[1] <= t0;
      tag_pipe[2] <= tag_pipe[1];
    end
  end

  always_comb begin
    pix = '0;
    if (tag_pipe[2].active)
      pix = tag_pipe[2].img ? vram.vout[14:0] : BORDER[14:0];
  end

  // Bit 15 of a VRAM word carries no colour
  logic unused_vout_msb;
  assign unused_vout_msb = vram.vout[15];

  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= {pix[14:10], pix[14:12]};
      vga_g       <= {pix[9:5],   pix[9:7]};
      vga_b       <= {pix[4:0],   pix[4:2]};
      vga_hs      <= tag_pipe[2].hs;
      vga_vs      <= tag_pipe[2].vs;
      vblank      <= tag_pipe[2].vb;
      frame_start <= tag_pipe[2].fs;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-geometry instance checked over whole frames plus a full 640x480
// instance checked over its first lines, both against a coordinate-level model, with literal spot checks.
module tb_vga_scanout;

  typedef struct {
    int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, iw, ih, sc, hoff, voff;
    logic [15:0] border;
  } cfg_t;

  logic vclk, rst, chk_en;
  int   cyc, n_pass, n_tot;
  cfg_t cs, cd;
  logic [15:0] eva_s, eva_d;

  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
  logic       s_hs, s_vs, s_vb, s_fs, d_hs, d_vs, d_vb, d_fs;

  vga_scanout_if s_if ();
  vga_scanout_if d_if ();

  // Small raster: line 56 cycles, frame 31 lines (1736 cycles), 8x6 image at (8,3), x3 scaling
  vga_scanout #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(8), .IMG_H(6), .SCALE(3), .H_OFF(8), .V_OFF(3),
    .BORDER(16'h03E0)
  ) dut_s (
    .vclk(vclk), .rst(rst), .vram(s_if.master),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .vblank(s_vb), .frame_start(s_fs)
  );

  vga_scanout #(.BORDER(16'h03E0)) dut_d (
    .vclk(vclk), .rst(rst), .vram(d_if.master),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
    .vblank(d_vb), .frame_start(d_fs)
  );

  initial begin
    vclk = 1'b0;
    forever #5 vclk = ~vclk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h7C00;
      16'h0001: return 16'h801F;
      default:  return a;
    endcase
  endfunction

  // VRAM: one registered read stage
  always @(posedge vclk) begin
    s_if.vout <= mem_word(s_if.vaddr);
    d_if.vout <= mem_word(d_if.vaddr);
  end

  always @(posedge vclk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  // Expected {r,g,b,hs,vs,vblank,frame_start} k cycles after reset release
  function automatic logic [28:0] model_out(input cfg_t c, input int k);
    int ht, vt, p, h, v;
    logic act, img;
    logic [15:0] w;
    if (k < 3) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    ht = c.ha + c.hfp + c.hsy + c.hbp;
    vt = c.va + c.vfp + c.vsy + c.vbp;
    p  = k - 3;
    h  = p % ht;
    v  = (p / ht) % vt;
    act = (h < c.ha) && (v < c.va);
    img = (h >= c.hoff) && (h < c.hoff + c.iw * c.sc) && (v >= c.voff) && (v < c.voff + c.ih * c.sc);
    w = 16'h0;
    if (act) w = img ? mem_word(16'(((v - c.voff) / c.sc) * c.iw + (h - c.hoff) / c.sc)) : c.border;
    return {w[14:10], w[14:12], w[9:5], w[9:7], w[4:0], w[4:2],
            !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsy)),
            !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsy)),
            (v >= c.va), (h == 0 && v == 0)};
  endfunction

  // Expected VRAM address at cycle k given the previous expectation (held outside the image)
  function automatic logic [15:0] va_step(input cfg_t c, input int k, input logic [15:0] prev);
    int ht, vt, p, h, v;
    if (k < 1) return prev;
    ht = c.ha + c.hfp + c.hsy + c.hbp;
    vt = c.va + c.vfp + c.vsy + c.vbp;
    p  = k - 1;
    h  = p % ht;
    v  = (p / ht) % vt;
    if ((h >= c.hoff) && (h < c.hoff + c.iw * c.sc) && (v >= c.voff) && (v < c.voff + c.ih * c.sc))
      return 16'(((v - c.voff) / c.sc) * c.iw + (h - c.hoff) / c.sc);
    return prev;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cyc %0d", nm, act, exp, cyc);
  endtask

  task automatic wait_k(input int n);
    int g;
    g = 0;
    while (cyc != n && g < 10000) begin
      @(negedge vclk);
      g++;
    end
    if (cyc != n) begin
      n_tot++;
      $display("FAIL wait_k: cyc %0d never reached %0d", cyc, n);
    end
  endtask

  always @(negedge vclk) begin
    if (chk_en) begin
      if (!rst) begin
        eva_s = 16'h0;
        eva_d = 16'h0;
      end else begin
        eva_s = va_step(cs, cyc, eva_s);
        eva_d = va_step(cd, cyc, eva_d);
      end
      chk("small_out", {s_r, s_g, s_b, s_hs, s_vs, s_vb, s_fs}, model_out(cs, cyc));
      chk("small_vaddr", s_if.vaddr, eva_s);
      chk("full_out", {d_r, d_g, d_b, d_hs, d_vs, d_vb, d_fs}, model_out(cd, cyc));
      chk("full_vaddr", d_if.vaddr, eva_d);
    end
  end

  initial begin
    n_pass = 0;
    n_tot  = 0;
    chk_en = 1'b0;
    eva_s  = 16'h0;
    eva_d  = 16'h0;
    cs = '{40, 4, 6, 6, 24, 2, 2, 3, 8, 6, 3, 8, 3, 16'h03E0};
    cd = '{640, 16, 96, 48, 480, 10, 2, 33, 128, 124, 3, 128, 54, 16'h03E0};
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge vclk);
    chk("rst_hs", s_hs, 1'b1);
    chk("rst_rgb", {s_r, s_g, s_b}, 24'h0);
    #2 rst = 1'b1;

    wait_k(3);    chk("fs_first_s", s_fs, 1'b1); chk("fs_first_d", d_fs, 1'b1);
    wait_k(4);    chk("fs_one_cycle", s_fs, 1'b0);
    wait_k(46);   chk("hs_before", s_hs, 1'b1);
    wait_k(47);   chk("hs_start", s_hs, 1'b0);
    wait_k(53);   chk("hs_end", s_hs, 1'b1);
    wait_k(130);  chk("full_border_g", d_g, 8'hFF);
    wait_k(177);  chk("vaddr_first", s_if.vaddr, 16'h0000);
    wait_k(178);  chk("border_left", {s_r, s_g, s_b}, 24'h00FF00);
    wait_k(179);  chk("pix00_red", {s_r, s_g, s_b}, 24'hFF0000);
    wait_k(180);  chk("vaddr_col1", s_if.vaddr, 16'h0001);
    wait_k(182);  chk("pix01_blue_b15", {s_r, s_g, s_b}, 24'h0000FF);
    wait_k(200);  chk("vaddr_col7", s_if.vaddr, 16'h0007);
    wait_k(201);  chk("vaddr_hold", s_if.vaddr, 16'h0007);
    wait_k(203);  chk("border_right", {s_r, s_g, s_b}, 24'h00FF00);
    wait_k(211);  chk("hblank_black", {s_r, s_g, s_b}, 24'h0);
    wait_k(345);  chk("vaddr_row1", s_if.vaddr, 16'h0008);
    wait_k(347);  chk("pix_row1", {s_r, s_g, s_b}, 24'h000042);
    wait_k(643);  chk("full_hblank", d_g, 8'h00);
    wait_k(658);  chk("full_hs_before", d_hs, 1'b1);
    wait_k(659);  chk("full_hs_start", d_hs, 1'b0);
    wait_k(754);  chk("full_hs_last", d_hs, 1'b0);
    wait_k(755);  chk("full_hs_end", d_hs, 1'b1);
    wait_k(1152); chk("vaddr_last", s_if.vaddr, 16'h002F);
    wait_k(1200); chk("vaddr_last_hold", s_if.vaddr, 16'h002F);
    wait_k(1346); chk("vblank_before", s_vb, 1'b0);
    wait_k(1347); chk("vblank_start", s_vb, 1'b1);
    wait_k(1458); chk("vs_before", s_vs, 1'b1);
    wait_k(1459); chk("vs_start", s_vs, 1'b0);
    wait_k(1738); chk("fs_gap", s_fs, 1'b0);
    wait_k(1739); chk("fs_period", s_fs, 1'b1);

    // Third frame, image row 2 col 1 -> word 0x0011
    wait_k(4047); chk("pre_reset_pix", s_b, 8'h8C);
    @(posedge vclk);
    #2 rst = 1'b0;
    #1;
    chk("async_rgb", {s_r, s_g, s_b}, 24'h0);
    chk("async_hs", s_hs, 1'b1);
    chk("async_vaddr", s_if.vaddr, 16'h0);
    repeat (3) @(negedge vclk);
    #2 rst = 1'b1;
    wait_k(2);    chk("rel_fs_early", s_fs, 1'b0);
    wait_k(3);    chk("rel_fs_s", s_fs, 1'b1); chk("rel_fs_d", d_fs, 1'b1);
    wait_k(182);  chk("rel_pix01", {s_r, s_g, s_b}, 24'h0000FF);
    wait_k(1739); chk("rel_fs_period", s_fs, 1'b1);
    wait_k(1760);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
